reg_port_arbiter: RTL and testbench
===================================

Name: reg_port_arbiter

Overview:
- Shares the single access port of the LED/control register file between two requesters.
- Requester 1 is the FSMC host bus slave. It issues one-cycle do_write/do_read pulses, has absolute priority, and is never stalled.
- Requester 2 is an internal master (UART command decoder, self-test). It uses a req/gnt handshake and is served only in cycles with no host access.
- Sits between the bus slave and the register file in the top level.

Parameters:
- AW, 2, register address width
- DW, 3, register data width
- CW, 8, width of the saturating blocked-cycle counter

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  reset; one clock, asynchronous, active-high
- h_do_write  in  1  host write pulse
- h_do_read  in  1  host read pulse
- h_adr  in  AW  host address, valid with either pulse
- h_wdata  in  DW  host write data
- h_rdata  out  DW  host read data, registered
- i_req  in  1  internal request, level; held until i_gnt
- i_we  in  1  internal op is a write (1) or read (0); held with i_req
- i_adr  in  AW  internal address; held with i_req
- i_wdata  in  DW  internal write data; held with i_req
- i_gnt  out  1  one-cycle grant; request consumed this cycle
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DW  internal read data, registered
- r_we  out  1  register file write strobe
- r_adr  out  AW  register file address
- r_wdata  out  DW  register file write data
- r_rdata  in  DW  register file read data, combinational from r_adr
- err_rw  out  1  sticky: h_do_write and h_do_read seen in the same cycle
- blk_cnt  out  CW  saturating count of cycles with i_req high and i_gnt low

Behaviour:
- Reset values: h_rdata=0, i_rdata=0, i_rvalid=0, err_rw=0, blk_cnt=0. Owner state = IDLE.
- Port outputs r_we, r_adr, r_wdata and i_gnt are combinational from the current-cycle inputs. They are 0 while rst is high.
- Per-cycle owner decode, priority order:
  - HOST: h_do_write|h_do_read. r_adr=h_adr. r_we=h_do_write. r_wdata=h_wdata. i_gnt=0.
  - INT: no host pulse and i_req. r_adr=i_adr. r_we=i_we. r_wdata=i_wdata. i_gnt=1.
  - IDLE: otherwise. r_we=0, r_adr=0, r_wdata=0.
- Host read:
  - h_rdata <= r_rdata at the posedge ending the h_do_read cycle.
  - Latency is 1 cycle, which matches the bus slave sampling read data one cycle after do_read.
  - h_rdata holds until the next host read.
- Internal read:
  - Applies in the cycle where i_gnt=1 and i_we=0.
  - i_rdata <= r_rdata; i_rvalid <= 1 for exactly one cycle.
  - i_rdata holds until the next internal read.
- Internal write: takes effect at the grant edge. No i_rvalid.
- Back-to-back internal ops: legal. The requester may present the next op in the cycle after i_gnt. Max internal throughput is 1 op/cycle when the host is idle.
- Simultaneous h_do_write & h_do_read:
  - Treated as a host write; the read is ignored and h_rdata is unchanged.
  - err_rw <= 1 and stays set until rst.
- Simultaneous host pulse and i_req: host served, i_gnt=0, blk_cnt increments. The internal request stays pending and is granted in the first host-free cycle.
- blk_cnt: +1 each cycle with i_req & ~i_gnt. Saturates at 2^CW-1, no wrap. Clears only on rst.
- i_req dropped before grant: the request is abandoned with no side effect. Requesters must not do this, but it must be harmless.
- Reset mid-operation: rst asserted in the cycle after an internal read grant clears i_rvalid immediately (asynchronous). The read result is lost.
- No internal FSM beyond the one-cycle i_rvalid pipeline stage. All arbitration is stateless per cycle, so the host is never delayed.

Test Plan:
- Host write then read:
  - h_do_write adr=2 data=5 -> r_we=1, r_adr=2, r_wdata=5 in that cycle.
  - Later h_do_read adr=2 with the file returning 5 -> h_rdata=5 one cycle later, i_gnt stays 0.
- Internal read, host idle: i_req=1 i_we=0 adr=1, file holds 3 -> i_gnt=1 same cycle; i_rvalid=1 with i_rdata=3 next cycle; blk_cnt=0.
- Collision:
  - i_req write adr=0 data=7 held.
  - Host do_write adr=3 data=1 in cycles 0 and 2.
  - Expected: host served in cycles 0 and 2; i_gnt only in cycle 1; blk_cnt=1. Then next op presented in cycle 2 blocked -> blk_cnt=2.
- Saturation: CW=2, i_req held high with a host pulse every cycle for 6 cycles -> blk_cnt 1,2,3,3,3,3, never granted.
- Illegal host pulse: h_do_write=h_do_read=1 adr=1 data=4 -> r_we=1, r_wdata=4, h_rdata unchanged, err_rw=1 sticky through 10 idle cycles until rst.
- Async reset: internal read granted, rst pulsed mid-cycle before the next edge -> i_rvalid, h_rdata, i_rdata, err_rw and blk_cnt all 0 immediately.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Shares the register file access port between the host bus slave
// (absolute priority, never stalled) and an internal req/gnt master.
module reg_port_arbiter #(
  parameter int AW = 2,
  parameter int DW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          h_do_write,
  input  logic          h_do_read,
  input  logic [AW-1:0] h_adr,
  input  logic [DW-1:0] h_wdata,
  output logic [DW-1:0] h_rdata,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          r_we,
  output logic [AW-1:0] r_adr,
  output logic [DW-1:0] r_wdata,
  input  logic [DW-1:0] r_rdata,
  output logic          err_rw,
  output logic [CW-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_HOST,
    OWN_INT
  } own_e;

  own_e          own;
  logic          h_rd_fire;
  logic          i_rd_fire;

  logic [DW-1:0] h_rdata_d, h_rdata_q;
  logic [DW-1:0] i_rdata_d, i_rdata_q;
  logic          i_rvalid_d, i_rvalid_q;
  logic          err_rw_d, err_rw_q;
  logic [CW-1:0] blk_cnt_d, blk_cnt_q;

  // Stateless per-cycle owner decode and port mux; host always wins.
  always_comb begin
    own     = OWN_IDLE;
    r_we    = 1'b0;
    r_adr   = '0;
    r_wdata = '0;
    i_gnt   = 1'b0;
    if (rst)
      own = OWN_IDLE;
    else if (h_do_write || h_do_read)
      own = OWN_HOST;
    else if (i_req)
      own = OWN_INT;
    case (own)
      OWN_HOST: begin
        r_adr   = h_adr;
        r_we    = h_do_write;
        r_wdata = h_wdata;
      end
      OWN_INT: begin
        r_adr   = i_adr;
        r_we    = i_we;
        r_wdata = i_wdata;
        i_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state for captured read data, read-valid, error and blocked count.
  always_comb begin
    h_rd_fire  = (own == OWN_HOST) && h_do_read && !h_do_write;
    i_rd_fire  = i_gnt && !i_we;
    h_rdata_d  = h_rdata_q;
    i_rdata_d  = i_rdata_q;
    i_rvalid_d = i_rd_fire;
    err_rw_d   = err_rw_q | (h_do_write & h_do_read);
    blk_cnt_d  = blk_cnt_q;
    if (h_rd_fire)
      h_rdata_d = r_rdata;
    if (i_rd_fire)
      i_rdata_d = r_rdata;
    if (i_req && !i_gnt && !(&blk_cnt_q))
      blk_cnt_d = blk_cnt_q + CW'(1);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_rdata_q  <= '0;
      i_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      err_rw_q   <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      h_rdata_q  <= h_rdata_d;
      i_rdata_q  <= i_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      err_rw_q   <= err_rw_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign h_rdata  = h_rdata_q;
  assign i_rdata  = i_rdata_q;
  assign i_rvalid = i_rvalid_q;
  assign err_rw   = err_rw_q;
  assign blk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed test-plan steps followed by
// random traffic, checked against a behavioural model with its own memory.
module tb_reg_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_do_write, h_do_read;
  logic [1:0] h_adr;
  logic [2:0] h_wdata;
  logic       i_req, i_we;
  logic [1:0] i_adr;
  logic [2:0] i_wdata;

  logic [2:0] h_rdata, i_rdata, r_wdata, r_rdata;
  logic       i_gnt, i_rvalid, r_we, err_rw;
  logic [1:0] r_adr;
  logic [7:0] blk_cnt;

  logic [2:0] h_rdata_s, i_rdata_s, r_wdata_s, r_rdata_s;
  logic       i_gnt_s, i_rvalid_s, r_we_s, err_rw_s;
  logic [1:0] r_adr_s;
  logic [1:0] blk_cnt_s;

  logic [2:0] mem [4];

  int checks = 0;
  int failures = 0;

  logic [2:0] mmem [4];
  logic [2:0] m_hr, m_ir;
  logic       m_rv, m_err, last_gnt;
  int         m_blk, m_blks;

  always #5 clk = ~clk;

  reg_port_arbiter dut (
    .clk(clk), .rst(rst),
    .h_do_write(h_do_write), .h_do_read(h_do_read),
    .h_adr(h_adr), .h_wdata(h_wdata), .h_rdata(h_rdata),
    .i_req(i_req), .i_we(i_we), .i_adr(i_adr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .r_we(r_we), .r_adr(r_adr), .r_wdata(r_wdata), .r_rdata(r_rdata),
    .err_rw(err_rw), .blk_cnt(blk_cnt)
  );

  reg_port_arbiter #(.AW(2), .DW(3), .CW(2)) dut_s (
    .clk(clk), .rst(rst),
    .h_do_write(h_do_write), .h_do_read(h_do_read),
    .h_adr(h_adr), .h_wdata(h_wdata), .h_rdata(h_rdata_s),
    .i_req(i_req), .i_we(i_we), .i_adr(i_adr), .i_wdata(i_wdata),
    .i_gnt(i_gnt_s), .i_rvalid(i_rvalid_s), .i_rdata(i_rdata_s),
    .r_we(r_we_s), .r_adr(r_adr_s), .r_wdata(r_wdata_s), .r_rdata(r_rdata_s),
    .err_rw(err_rw_s), .blk_cnt(blk_cnt_s)
  );

  // Register file behind the port: combinational read, clocked write.
  assign r_rdata   = mem[r_adr];
  assign r_rdata_s = mem[r_adr_s];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) mem[k] <= 3'd0;
    end else if (r_we) begin
      mem[r_adr] <= r_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("h_rdata", 32'(h_rdata), 32'(m_hr));
    chk("i_rdata", 32'(i_rdata), 32'(m_ir));
    chk("i_rvalid", 32'(i_rvalid), 32'(m_rv));
    chk("err_rw", 32'(err_rw), 32'(m_err));
    chk("blk_cnt", 32'(blk_cnt), 32'(m_blk));
    chk("blk_cnt_s", 32'(blk_cnt_s), 32'(m_blks));
  endtask

  task automatic model_clear();
    m_hr = 3'd0; m_ir = 3'd0; m_rv = 1'b0; m_err = 1'b0;
    m_blk = 0; m_blks = 0; last_gnt = 1'b0;
  endtask

  task automatic idle_inputs();
    h_do_write = 1'b0; h_do_read = 1'b0; h_adr = 2'd0; h_wdata = 3'd0;
    i_req = 1'b0; i_we = 1'b0; i_adr = 2'd0; i_wdata = 3'd0;
  endtask

  // Synchronous-span reset: held across one edge, clears the file too.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_r_we", 32'(r_we), 32'd0);
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    model_clear();
    chk_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mmem[k] = 3'd0;
  endtask

  // One clock cycle: drive, check port mux, clock, check registers.
  task automatic cyc(input logic wr, input logic rd,
                     input logic [1:0] ha, input logic [2:0] hd,
                     input logic rq, input logic we,
                     input logic [1:0] ia, input logic [2:0] id);
    logic host, gnt, ewe;
    logic [1:0] ea;
    logic [2:0] ed, rdv;
    h_do_write = wr; h_do_read = rd; h_adr = ha; h_wdata = hd;
    i_req = rq; i_we = we; i_adr = ia; i_wdata = id;
    #2;
    host = wr | rd;
    gnt  = !host && rq;
    ea   = host ? ha : (gnt ? ia : 2'd0);
    ewe  = host ? wr : (gnt && we);
    ed   = host ? hd : (gnt ? id : 3'd0);
    chk("r_we", 32'(r_we), 32'(ewe));
    chk("r_adr", 32'(r_adr), 32'(ea));
    chk("r_wdata", 32'(r_wdata), 32'(ed));
    chk("i_gnt", 32'(i_gnt), 32'(gnt));
    chk("i_gnt_s", 32'(i_gnt_s), 32'(gnt));
    rdv = mmem[ea];
    @(posedge clk);
    #1;
    if (ewe) mmem[ea] = ed;
    if (rd && !wr) m_hr = rdv;
    m_rv = gnt && !we;
    if (m_rv) m_ir = rdv;
    if (wr && rd) m_err = 1'b1;
    if (rq && !gnt) begin
      if (m_blk < 255) m_blk++;
      if (m_blks < 3) m_blks++;
    end
    last_gnt = gnt;
    chk_regs();
  endtask

  int         sat_exp [6] = '{1, 2, 3, 3, 3, 3};
  logic       p_rq, p_we, hw, hr;
  logic [1:0] p_adr;
  logic [2:0] p_wd;

  initial begin
    do_reset();

    // saturation of the narrow counter under continuous host traffic
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 2'd3, 3'd1, 1, 1, 2'd0, 3'd7);
      chk("sat_blk", 32'(blk_cnt_s), 32'(sat_exp[i]));
    end

    // host write then read back
    do_reset();
    cyc(1, 0, 2'd2, 3'd5, 0, 0, 2'd0, 3'd0);
    cyc(0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 3'd0);
    cyc(0, 1, 2'd2, 3'd0, 0, 0, 2'd0, 3'd0);
    chk("host_rd", 32'(h_rdata), 32'd5);

    // internal read with host idle
    cyc(1, 0, 2'd1, 3'd3, 0, 0, 2'd0, 3'd0);
    cyc(0, 0, 2'd0, 3'd0, 1, 0, 2'd1, 3'd0);
    chk("int_rd", 32'(i_rdata), 32'd3);
    chk("int_rv", 32'(i_rvalid), 32'd1);
    chk("int_blk", 32'(blk_cnt), 32'd0);

    // collision between host writes and a held internal write
    do_reset();
    cyc(1, 0, 2'd3, 3'd1, 1, 1, 2'd0, 3'd7);
    cyc(0, 0, 2'd0, 3'd0, 1, 1, 2'd0, 3'd7);
    chk("col_gnt", 32'(last_gnt), 32'd1);
    chk("col_blk1", 32'(blk_cnt), 32'd1);
    cyc(1, 0, 2'd3, 3'd1, 1, 1, 2'd2, 3'd5);
    chk("col_blk2", 32'(blk_cnt), 32'd2);
    cyc(0, 0, 2'd0, 3'd0, 1, 1, 2'd2, 3'd5);
    cyc(0, 1, 2'd0, 3'd0, 0, 0, 2'd0, 3'd0);
    chk("col_mem0", 32'(h_rdata), 32'd7);

    // simultaneous write and read pulses
    do_reset();
    cyc(1, 0, 2'd1, 3'd6, 0, 0, 2'd0, 3'd0);
    cyc(0, 1, 2'd1, 3'd0, 0, 0, 2'd0, 3'd0);
    cyc(1, 1, 2'd1, 3'd4, 0, 0, 2'd0, 3'd0);
    chk("ill_hr", 32'(h_rdata), 32'd6);
    for (int i = 0; i < 10; i++) cyc(0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 3'd0);
    chk("ill_err", 32'(err_rw), 32'd1);
    cyc(0, 1, 2'd1, 3'd0, 0, 0, 2'd0, 3'd0);
    chk("ill_wr", 32'(h_rdata), 32'd4);

    // asynchronous reset right after an internal read grant
    cyc(0, 0, 2'd0, 3'd0, 1, 0, 2'd1, 3'd0);
    cyc(1, 0, 2'd0, 3'd0, 1, 0, 2'd1, 3'd0);
    cyc(0, 0, 2'd0, 3'd0, 1, 0, 2'd1, 3'd0);
    chk("ar_pre_rv", 32'(i_rvalid), 32'd1);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("ar_rv", 32'(i_rvalid), 32'd0);
    chk("ar_hr", 32'(h_rdata), 32'd0);
    chk("ar_ir", 32'(i_rdata), 32'd0);
    chk("ar_err", 32'(err_rw), 32'd0);
    chk("ar_blk", 32'(blk_cnt), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_regs();

    // random traffic; the internal requester holds its op until granted
    p_rq = 1'b0; p_we = 1'b0; p_adr = 2'd0; p_wd = 3'd0;
    for (int n = 0; n < 400; n++) begin
      hw = ($urandom_range(0, 99) < 25);
      hr = ($urandom_range(0, 99) < 25);
      if (hw && hr && $urandom_range(0, 99) < 80) hr = 1'b0;
      if (!p_rq && $urandom_range(0, 99) < 60) begin
        p_rq  = 1'b1;
        p_we  = 1'($urandom_range(0, 1));
        p_adr = 2'($urandom_range(0, 3));
        p_wd  = 3'($urandom_range(0, 7));
      end else if (p_rq && $urandom_range(0, 99) < 3) begin
        p_rq = 1'b0;
      end
      cyc(hw, hr, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          p_rq, p_we, p_adr, p_wd);
      if (last_gnt) p_rq = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
